// File: rtl/rst_ctrl.sv
// Central reset controller: sequences power-on release, software domain resets and fault escalation.
// Bus access answers one cycle after req, and is answered even while domains are held in reset.
module rst_ctrl #(
  parameter int XLEN        = 32,
  parameter int RST_WIDTH   = 10,
  parameter int HOLD_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [XLEN-1:0]      addr,
  input  logic                 w_rb,
  input  logic [1:0]           acc,
  input  logic [XLEN-1:0]      wdata,
  output logic [XLEN-1:0]      rdata,
  input  logic                 req,
  output logic                 resp,
  output logic                 rst_fault,
  input  logic                 fault,
  input  logic [7:0]           fault_cause,
  input  logic [XLEN-1:0]      fault_addr,
  output logic [RST_WIDTH-1:0] rstn_vec
);

  localparam int RST_MISC    = 0;
  localparam int RST_CORE    = 1;
  localparam int RST_ROM     = 2;
  localparam int RST_TCM     = 3;
  localparam int RST_SRAM    = 4;
  localparam int RST_QSPINOR = 5;
  localparam int RST_GPIO    = 6;
  localparam int RST_UART    = 7;
  localparam int RST_TMR     = 8;
  localparam int RST_EIC     = 9;

  localparam logic [RST_WIDTH-1:0] ONE         = RST_WIDTH'(1);
  localparam logic [RST_WIDTH-1:0] MASK_MISC   = ONE << RST_MISC;
  localparam logic [RST_WIDTH-1:0] MASK_CORE   = ONE << RST_CORE;
  localparam logic [RST_WIDTH-1:0] MASK_MEM    = (ONE << RST_ROM) | (ONE << RST_TCM) |
                                                 (ONE << RST_SRAM) | (ONE << RST_QSPINOR);
  localparam logic [RST_WIDTH-1:0] MASK_PERIPH = (ONE << RST_GPIO) | (ONE << RST_UART) |
                                                 (ONE << RST_TMR) | (ONE << RST_EIC);

  localparam logic [7:0] CAUSE_POR = 8'h00;
  localparam logic [7:0] CAUSE_SW  = 8'h01;
  // Fault codes 0x10+i are raised by domain i; all other codes have no owning domain.
  localparam logic [7:0] FAULT_DOM_BASE = 8'h10;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);
  localparam logic [7:0] HOLD_N    = 8'(HOLD_CYCLES);

  typedef enum logic [2:0] {HOLD, REL0, REL1, REL2, RUN, SWRST} state_e;

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [RST_WIDTH-1:0]  vec_q, vec_d;
  logic [RST_WIDTH-1:0]  mask_q, mask_d;
  logic [7:0]            cause_q, cause_d;
  logic [XLEN-1:0]       faddr_q, faddr_d;
  logic                  resp_q, resp_d;
  logic                  flt_q, flt_d;
  logic [XLEN-1:0]       rdata_q, rdata_d;

  logic                  legal;
  logic                  ctrl_wr;
  logic [RST_WIDTH-1:0]  wmask;
  logic                  fault_in_mask;
  logic                  unused_bits;

  assign unused_bits = ^{addr[XLEN-1:4], wdata[XLEN-1:RST_WIDTH]};

  always_comb begin
    legal   = (acc == 2'd2) && (addr[1:0] == 2'b00) &&
              (w_rb ? (addr[3:2] == 2'd0) : (addr[3:2] != 2'd0));
    ctrl_wr = req && legal && w_rb;
    wmask   = wdata[RST_WIDTH-1:0];

    fault_in_mask = 1'b0;
    for (int i = 0; i < RST_WIDTH; i++) begin
      if (mask_q[i] && (fault_cause == FAULT_DOM_BASE + 8'(i))) fault_in_mask = 1'b1;
    end

    resp_d  = req;
    flt_d   = req && !legal;
    rdata_d = '0;
    if (req && legal && !w_rb) begin
      case (addr[3:2])
        2'd1:    rdata_d = XLEN'(cause_q);
        2'd2:    rdata_d = faddr_q;
        2'd3:    rdata_d = XLEN'(vec_q);
        default: rdata_d = '0;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    mask_d  = mask_q;
    cause_d = cause_q;
    faddr_d = faddr_q;

    case (state_q)
      HOLD: begin
        vec_d = '0;
        if (cnt_q == HOLD_LAST) begin
          state_d = REL0;
          cnt_d   = '0;
          vec_d   = MASK_MISC;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      REL0: begin
        state_d = REL1;
        vec_d   = vec_q | MASK_MEM;
      end
      REL1: begin
        state_d = REL2;
        vec_d   = vec_q | MASK_PERIPH;
      end
      REL2: begin
        state_d = RUN;
        vec_d   = vec_q | MASK_CORE;
      end
      RUN: begin
        if (fault) begin
          state_d = HOLD;
          cnt_d   = '0;
          vec_d   = '0;
          cause_d = fault_cause;
          faddr_d = fault_addr;
        end else if (ctrl_wr && (wmask != '0)) begin
          cause_d = CAUSE_SW;
          cnt_d   = '0;
          if (wmask[RST_MISC]) begin
            state_d = HOLD;
            vec_d   = '0;
          end else begin
            // vec is left alone this cycle so the core's store completes before its domains drop.
            state_d = SWRST;
            mask_d  = wmask;
          end
        end
      end
      SWRST: begin
        if (fault && !fault_in_mask) begin
          state_d = HOLD;
          cnt_d   = '0;
          vec_d   = '0;
          cause_d = fault_cause;
          faddr_d = fault_addr;
        end else if (cnt_q == HOLD_N) begin
          state_d = RUN;
          cnt_d   = '0;
          vec_d   = vec_q | mask_q;
        end else begin
          cnt_d = cnt_q + 8'd1;
          vec_d = vec_q & ~mask_q;
        end
      end
      default: begin
        state_d = HOLD;
        cnt_d   = '0;
        vec_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= HOLD;
      cnt_q   <= '0;
      vec_q   <= '0;
      mask_q  <= '0;
      cause_q <= CAUSE_POR;
      faddr_q <= '0;
      resp_q  <= 1'b0;
      flt_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      mask_q  <= mask_d;
      cause_q <= cause_d;
      faddr_q <= faddr_d;
      resp_q  <= resp_d;
      flt_q   <= flt_d;
      rdata_q <= rdata_d;
    end
  end

  assign rstn_vec  = vec_q;
  assign resp      = resp_q;
  assign rst_fault = flt_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_rst_ctrl.sv
// Directed bench for rst_ctrl: POR, software, fault, illegal-access, collision and mid-sequence reset cases.
module tb_rst_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] addr;
  logic        w_rb;
  logic [1:0]  acc;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        req;
  logic        resp;
  logic        rst_fault;
  logic        fault;
  logic [7:0]  fault_cause;
  logic [31:0] fault_addr;
  logic [9:0]  rstn_vec;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  rst_ctrl #(.XLEN(32), .RST_WIDTH(10), .HOLD_CYCLES(16)) dut (
    .clk(clk), .rstn(rstn), .addr(addr), .w_rb(w_rb), .acc(acc), .wdata(wdata),
    .rdata(rdata), .req(req), .resp(resp), .rst_fault(rst_fault), .fault(fault),
    .fault_cause(fault_cause), .fault_addr(fault_addr), .rstn_vec(rstn_vec)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic w, input logic [31:0] a, input logic [1:0] sz, input logic [31:0] d,
                     output logic [31:0] rd, output logic rsp, output logic flt);
    req = 1'b1; w_rb = w; addr = a; acc = sz; wdata = d;
    tick();
    req = 1'b0; w_rb = 1'b0; addr = '0; acc = 2'd0; wdata = '0;
    rd = rdata; rsp = resp; flt = rst_fault;
  endtask

  task automatic rd_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] rd; logic rsp, flt;
    bus(1'b0, a, 2'd2, 32'h0, rd, rsp, flt);
    check({tag, " resp/flt"}, {30'b0, rsp, flt}, 32'h2);
    check(tag, rd, exp);
  endtask

  // Call with the domains freshly in HOLD and the counter at zero.
  task automatic release_seq(input string tag);
    check({tag, " hold"}, 32'(rstn_vec), 32'h000);
    for (int i = 0; i < 15; i++) begin
      tick();
      check({tag, " hold"}, 32'(rstn_vec), 32'h000);
    end
    tick(); check({tag, " misc"},   32'(rstn_vec), 32'h001);
    tick(); check({tag, " mem"},    32'(rstn_vec), 32'h03D);
    tick(); check({tag, " periph"}, 32'(rstn_vec), 32'h3FD);
    tick(); check({tag, " core"},   32'(rstn_vec), 32'h3FF);
  endtask

  task automatic wait_vec(input string tag, input logic [9:0] v);
    int k = 0;
    while (rstn_vec !== v && k < 200) begin
      tick();
      k++;
    end
    check(tag, 32'(rstn_vec), 32'(v));
  endtask

  logic [31:0] rd;
  logic        rsp, flt;

  initial begin
    rstn = 1'b0; addr = '0; w_rb = 1'b0; acc = 2'd0; wdata = '0; req = 1'b0;
    fault = 1'b0; fault_cause = '0; fault_addr = '0;

    // Power-on reset
    repeat (5) tick();
    check("rst vec",   32'(rstn_vec), 32'h0);
    check("rst resp",  32'(resp), 32'h0);
    check("rst fault", 32'(rst_fault), 32'h0);
    check("rst rdata", rdata, 32'h0);
    rstn = 1'b1;
    release_seq("por");
    rd_reg("por cause", 32'h4, 32'h00);
    rd_reg("por faddr", 32'h8, 32'h0);
    rd_reg("por stat",  32'hC, 32'h3FF);

    // Partial software reset of uart
    bus(1'b1, 32'h0, 2'd2, 32'h80, rd, rsp, flt);
    check("sw resp",     {30'b0, rsp, flt}, 32'h2);
    check("sw vec@resp", 32'(rstn_vec), 32'h3FF);
    for (int i = 0; i < 16; i++) begin
      if (i == 4) begin
        bus(1'b0, 32'hC, 2'd2, 32'h0, rd, rsp, flt);
        check("sw stat", rd, 32'h37F);
      end else begin
        tick();
      end
      check("sw uart low", 32'(rstn_vec), 32'h37F);
    end
    tick();
    check("sw uart rel", 32'(rstn_vec), 32'h3FF);
    rd_reg("sw cause", 32'h4, 32'h01);

    // Fault escalation from RUN
    fault = 1'b1; fault_cause = 8'h20; fault_addr = 32'h2000_0010;
    tick();
    fault = 1'b0;
    release_seq("flt");
    rd_reg("flt cause", 32'h4, 32'h20);
    rd_reg("flt faddr", 32'h8, 32'h2000_0010);

    // Illegal accesses
    bus(1'b0, 32'h4, 2'd0, 32'h0, rd, rsp, flt);
    check("ill byte rd", {rd[29:0], rsp, flt}, 32'h3);
    bus(1'b1, 32'h8, 2'd2, 32'hDEAD_BEEF, rd, rsp, flt);
    check("ill wr faddr", {rd[29:0], rsp, flt}, 32'h3);
    bus(1'b0, 32'h5, 2'd2, 32'h0, rd, rsp, flt);
    check("ill unaligned", {rd[29:0], rsp, flt}, 32'h3);
    bus(1'b1, 32'h0, 2'd1, 32'h80, rd, rsp, flt);
    check("ill half ctrl", {30'b0, rsp, flt}, 32'h3);
    bus(1'b0, 32'h0, 2'd2, 32'h0, rd, rsp, flt);
    check("ill rd ctrl", {rd[29:0], rsp, flt}, 32'h3);
    repeat (3) tick();
    check("ill vec", 32'(rstn_vec), 32'h3FF);
    rd_reg("ill faddr", 32'h8, 32'h2000_0010);
    rd_reg("ill cause", 32'h4, 32'h20);

    // Fault owned by a masked domain during SWRST is ignored
    bus(1'b1, 32'h0, 2'd2, 32'h80, rd, rsp, flt);
    repeat (2) tick();
    fault = 1'b1; fault_cause = 8'h17; fault_addr = 32'h0000_0077;
    tick();
    fault = 1'b0;
    check("mask flt vec", 32'(rstn_vec), 32'h37F);
    wait_vec("mask flt rel", 10'h3FF);
    rd_reg("mask flt cause", 32'h4, 32'h01);

    // Fault from an unmasked domain during SWRST escalates
    bus(1'b1, 32'h0, 2'd2, 32'h80, rd, rsp, flt);
    tick();
    fault = 1'b1; fault_cause = 8'h16; fault_addr = 32'h0000_0044;
    tick();
    fault = 1'b0;
    release_seq("swflt");
    rd_reg("swflt cause", 32'h4, 32'h16);
    rd_reg("swflt faddr", 32'h8, 32'h44);

    // Fault and CTRL write in the same cycle
    fault = 1'b1; fault_cause = 8'h21; fault_addr = 32'h0000_1234;
    bus(1'b1, 32'h0, 2'd2, 32'h40, rd, rsp, flt);
    fault = 1'b0;
    check("col resp", {30'b0, rsp, flt}, 32'h2);
    release_seq("col");
    repeat (20) tick();
    check("col no sw", 32'(rstn_vec), 32'h3FF);
    rd_reg("col cause", 32'h4, 32'h21);

    // External reset during REL1
    bus(1'b1, 32'h0, 2'd2, 32'h1, rd, rsp, flt);
    check("full sw vec", 32'(rstn_vec), 32'h0);
    rd_reg("full sw cause", 32'h4, 32'h01);
    wait_vec("reach rel1", 10'h03D);
    rstn = 1'b0;
    tick();
    check("mid vec", 32'(rstn_vec), 32'h0);
    rstn = 1'b1;
    release_seq("mid");
    rd_reg("mid cause", 32'h4, 32'h00);
    rd_reg("mid faddr", 32'h8, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
